// File: rtl/bit_reverse_reorder_pkg.sv
// Shared constants, types and helper functions for the bit-reverse reorder stage.
package bit_reverse_reorder_pkg;

    // Read-side sequencer states.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Ceiling log2, used to size counters from the frame length.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Reverse the low nbits of v; higher bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] src;
        logic [31:0] r;
        src = v;
        r   = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < nbits) begin
                r   = {r[30:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse_reorder_if.sv
// Streaming bus of the reorder stage: bit-reversed samples in, natural-order samples out.
interface bit_reverse_reorder_if #(
    parameter int WIDTH = 16
);
    logic             idata_en;
    logic [WIDTH-1:0] idata_r;
    logic [WIDTH-1:0] idata_i;
    logic             odata_en;
    logic [WIDTH-1:0] odata_r;
    logic [WIDTH-1:0] odata_i;
    logic             odata_last;

    // Producer of input frames / consumer of reordered output.
    modport master (
        output idata_en, idata_r, idata_i,
        input  odata_en, odata_r, odata_i, odata_last
    );

    // The reorder block itself.
    modport slave (
        input  idata_en, idata_r, idata_i,
        output odata_en, odata_r, odata_i, odata_last
    );
endinterface

// File: rtl/bit_reverse_reorder_ram.sv
// Frame store: one write port, one registered read port, no reset on contents.
module bit_reverse_reorder_ram #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    // Synchronous write and registered read; address {bank, index}.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: stores each bit-reversed FFT frame and replays it
// in natural order, gapless for back-to-back frames.
module bit_reverse_reorder
    import bit_reverse_reorder_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    bit_reverse_reorder_if.slave bus
);
    localparam int unsigned      LOG_N    = log2c(N);
    localparam int               AW       = LOG_N + 1;
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    // Write side
    logic [LOG_N-1:0] wr_count_q, wr_count_d;
    logic             wr_bank_q, wr_bank_d;
    logic             frame_ready_q, frame_ready_d;
    logic             ready_bank_q, ready_bank_d;

    // Read side
    rd_state_e        state_q;
    logic [LOG_N-1:0] rd_count_q;
    logic             rd_bank_q;
    logic             odata_en_q;
    logic             odata_last_q;

    // RAM hookup
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    ram_raddr;
    logic [2*WIDTH-1:0] ram_wdata;
    logic [2*WIDTH-1:0] ram_rdata;

    // Write-side next state: count samples, swap banks on a complete frame,
    // drop any partial frame when enable falls.
    always_comb begin
        wr_count_d    = wr_count_q;
        wr_bank_d     = wr_bank_q;
        frame_ready_d = 1'b0;
        ready_bank_d  = ready_bank_q;
        if (bus.idata_en) begin
            if (wr_count_q == LAST_IDX) begin
                wr_count_d    = '0;
                wr_bank_d     = ~wr_bank_q;
                frame_ready_d = 1'b1;
                ready_bank_d  = wr_bank_q;
            end else begin
                wr_count_d = wr_count_q + LOG_N'(1);
            end
        end else begin
            wr_count_d = '0;
        end
    end

    // Write-side registers; frame_ready is a one-cycle pulse to the reader.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count_q    <= '0;
            wr_bank_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            ready_bank_q  <= 1'b0;
        end else begin
            wr_count_q    <= wr_count_d;
            wr_bank_q     <= wr_bank_d;
            frame_ready_q <= frame_ready_d;
            ready_bank_q  <= ready_bank_d;
        end
    end

    assign ram_we    = bus.idata_en & ~reset;
    assign ram_waddr = {wr_bank_q, wr_count_q};
    assign ram_wdata = {bus.idata_r, bus.idata_i};

    // Natural-order replay: sample k lives at input position bitrev(k).
    assign ram_raddr = {rd_bank_q, LOG_N'(bitrev(32'(rd_count_q), LOG_N))};

    // Read sequencer with registered output flags aligned to the RAM read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= RD_IDLE;
            rd_count_q   <= '0;
            rd_bank_q    <= 1'b0;
            odata_en_q   <= 1'b0;
            odata_last_q <= 1'b0;
        end else begin
            odata_en_q   <= (state_q == RD_READ);
            odata_last_q <= (state_q == RD_READ) && (rd_count_q == LAST_IDX);
            case (state_q)
                RD_IDLE: begin
                    if (frame_ready_q) begin
                        state_q    <= RD_READ;
                        rd_count_q <= '0;
                        rd_bank_q  <= ready_bank_q;
                    end
                end
                RD_READ: begin
                    if (rd_count_q == LAST_IDX) begin
                        rd_count_q <= '0;
                        if (frame_ready_q) begin
                            // Next frame finished exactly now: continue without a gap.
                            rd_bank_q <= ready_bank_q;
                        end else begin
                            state_q <= RD_IDLE;
                        end
                    end else begin
                        rd_count_q <= rd_count_q + LOG_N'(1);
                    end
                end
                default: begin
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    bit_reverse_reorder_ram #(
        .AW (AW),
        .DW (2 * WIDTH)
    ) u_ram (
        .clk_i   (clock),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Data is forced to zero outside valid output cycles.
    assign bus.odata_en   = odata_en_q;
    assign bus.odata_last = odata_last_q;
    assign bus.odata_r    = odata_en_q ? ram_rdata[2*WIDTH-1:WIDTH] : '0;
    assign bus.odata_i    = odata_en_q ? ram_rdata[WIDTH-1:0]       : '0;

endmodule
